// File: rtl/fifo_sync_controller.sv
`default_nettype none
// ============================================================================
// Module : fifo_sync_controller
// Brief  : Pointer, occupancy and flag controller sequencing a byte memory as a FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_sync_controller #(
    parameter int N        = 16,
    parameter int DEPTH    = 16'h6800,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wrReq,
    input  logic [7:0]   wrDataIn,
    input  logic         rdReq,
    input  logic         clrErr,
    output logic         memWrEn,
    output logic [N-1:0] memWrPtr,
    output logic [7:0]   memWrData,
    output logic [N-1:0] memRdPtr,
    output logic         rdValid,
    output logic         full,
    output logic         empty,
    output logic         almostFull,
    output logic         almostEmpty,
    output logic [N:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [N-1:0] LAST_PTR = N'(DEPTH - 1);
    localparam logic [N:0]   DEPTH_C  = (N + 1)'(DEPTH);
    localparam logic [N:0]   AF_C     = (N + 1)'(AF_LEVEL);
    localparam logic [N:0]   AE_C     = (N + 1)'(AE_LEVEL);

    logic [N-1:0] wr_ptr;
    logic [N-1:0] rd_ptr;
    logic         wr_acc;
    logic         rd_acc;
    logic [N:0]   count_next;

    // Acceptance uses only registered flags, so no fall-through or full bypass.
    assign wr_acc     = wrReq & ~full;
    assign rd_acc     = rdReq & ~empty;
    assign count_next = count + (N + 1)'(wr_acc) - (N + 1)'(rd_acc);

    assign memWrEn   = wr_acc;
    assign memWrPtr  = wr_ptr;
    assign memWrData = wrDataIn;
    assign memRdPtr  = rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almostFull  <= 1'b0;
            almostEmpty <= 1'b1;
            rdValid     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count       <= count_next;
            full        <= (count_next == DEPTH_C);
            empty       <= (count_next == '0);
            almostFull  <= (count_next >= AF_C);
            almostEmpty <= (count_next <= AE_C);
            rdValid     <= rd_acc;
            // A new error event outranks a simultaneous clear.
            overflow    <= (wrReq & full)  | (overflow  & ~clrErr);
            underflow   <= (rdReq & empty) | (underflow & ~clrErr);
        end
    end

endmodule
`default_nettype wire
